// File: rtl/rat_intc_pkg.sv
// Shared definitions for the RAT interrupt controller: FSM states,
// default I/O port map and VECTOR register field positions.
package rat_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } intc_state_e;

    localparam logic [7:0] DEF_PORT_STAT = 8'h30;
    localparam logic [7:0] DEF_PORT_MASK = 8'h31;
    localparam logic [7:0] DEF_PORT_LVL  = 8'h32;
    localparam logic [7:0] DEF_PORT_VEC  = 8'h33;

    localparam int unsigned VEC_VALID_BIT = 7;
    localparam int unsigned VEC_IDX_LSB   = 0;
    localparam int unsigned VEC_IDX_W     = 3;

endpackage

// File: rtl/rat_irq_sync.sv
// One request line: 2-flop synchronizer, edge flop and set generation
// (level mode follows the synchronized input, edge mode fires on 0->1).
module rat_irq_sync
    import rat_intc_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic irq_i,
    input  logic level_i,
    output logic set_o
);

    logic s1_q, s2_q, s3_q;

    // Synchronize the asynchronous request and keep one delayed copy for edge detect
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= irq_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Pending-bit set condition for the selected trigger mode
    always_comb begin
        set_o = level_i ? s2_q : (s2_q & ~s3_q);
    end

endmodule

// File: rtl/rat_intr_ctrl.sv
// RAT CPU interrupt controller: synchronizes IRQ_IN, latches pending bits,
// applies a mask, and drives INTERRUPT with a post-service hold-off.
// Programmed over the CPU port bus (STATUS W1C, MASK, LEVEL).
// Optional macro RAT_INTC_VECTOR_EN adds the read-only VECTOR register.
module rat_intr_ctrl
    import rat_intc_pkg::*;
#(
    parameter int unsigned N_SRC       = 8,
    parameter logic [7:0]  PORT_STAT   = DEF_PORT_STAT,
    parameter logic [7:0]  PORT_MASK   = DEF_PORT_MASK,
    parameter logic [7:0]  PORT_LVL    = DEF_PORT_LVL,
`ifdef RAT_INTC_VECTOR_EN
    parameter logic [7:0]  PORT_VEC    = DEF_PORT_VEC,
`endif
    parameter int unsigned HOLDOFF_CYC = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    output logic [7:0]       IN_DATA,
    output logic             IN_HIT,
    output logic             INTERRUPT
);

    logic [N_SRC-1:0] set_w, clr_w, masked_w;
    logic [N_SRC-1:0] pend_q, pend_d, mask_q, level_q;
    logic             act_w, wr_stat_w, wr_mask_w, wr_lvl_w;
    intc_state_e      state_q;
    logic [3:0]       cnt_q;
    logic             intr_q;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        rat_irq_sync u_sync (
            .CLK     (CLK),
            .RESET   (RESET),
            .irq_i   (IRQ_IN[g]),
            .level_i (level_q[g]),
            .set_o   (set_w[g])
        );
    end

    // Port write decode and pending-bit next state (set wins over clear)
    always_comb begin
        wr_stat_w = IO_STRB && (PORT_ID == PORT_STAT);
        wr_mask_w = IO_STRB && (PORT_ID == PORT_MASK);
        wr_lvl_w  = IO_STRB && (PORT_ID == PORT_LVL);
        clr_w     = wr_stat_w ? OUT_PORT[N_SRC-1:0] : '0;
        pend_d    = set_w | (pend_q & ~clr_w);
        masked_w  = pend_q & mask_q;
        act_w     = |masked_w;
    end

    // Pending, mask and level registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_q  <= '0;
            mask_q  <= '0;
            level_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_mask_w) mask_q  <= OUT_PORT[N_SRC-1:0];
            if (wr_lvl_w)  level_q <= OUT_PORT[N_SRC-1:0];
        end
    end

    // Request FSM with registered INTERRUPT and hold-off counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            intr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (act_w) begin
                        state_q <= ST_ACTIVE;
                        intr_q  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!act_w) begin
                        intr_q <= 1'b0;
                        if (HOLDOFF_CYC == 0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_HOLDOFF;
                            cnt_q   <= 4'(HOLDOFF_CYC);
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign INTERRUPT = intr_q;

`ifdef RAT_INTC_VECTOR_EN
    logic [VEC_IDX_W-1:0] vidx_w;
    logic                 vfound_w;
    logic [7:0]           vec_w;

    // Priority encode the lowest-numbered active source into VECTOR
    always_comb begin
        vidx_w   = '0;
        vfound_w = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (masked_w[i] && !vfound_w) begin
                vidx_w   = i[VEC_IDX_W-1:0];
                vfound_w = 1'b1;
            end
        end
        vec_w = '0;
        vec_w[VEC_VALID_BIT] = act_w;
        vec_w[VEC_IDX_LSB +: VEC_IDX_W] = vidx_w;
    end
`endif

    // Combinational read mux; unmapped ports read zero with IN_HIT low
    always_comb begin
        IN_DATA = '0;
        IN_HIT  = 1'b0;
        if (PORT_ID == PORT_STAT) begin
            IN_DATA = 8'(pend_q);
            IN_HIT  = 1'b1;
        end else if (PORT_ID == PORT_MASK) begin
            IN_DATA = 8'(mask_q);
            IN_HIT  = 1'b1;
        end else if (PORT_ID == PORT_LVL) begin
            IN_DATA = 8'(level_q);
            IN_HIT  = 1'b1;
        end
`ifdef RAT_INTC_VECTOR_EN
        else if (PORT_ID == PORT_VEC) begin
            IN_DATA = vec_w;
            IN_HIT  = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Self-checking bench for rat_intr_ctrl: directed scenarios plus random
// traffic compared against a sample-history reference model.
module tb_rat_intr_ctrl;

    localparam int HO = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] IRQ_IN = 8'h00;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic [7:0] IN_DATA;
    logic       IN_HIT;
    logic       INTERRUPT;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0] m_pend = 8'h00, m_mask = 8'h00, m_lvl = 8'h00;
    logic [7:0] m_smp [3];
    bit         m_intr = 1'b0;
    int         m_quiet = 0;

    rat_intr_ctrl #(
        .N_SRC       (8),
        .HOLDOFF_CYC (HO)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IRQ_IN    (IRQ_IN),
        .PORT_ID   (PORT_ID),
        .OUT_PORT  (OUT_PORT),
        .IO_STRB   (IO_STRB),
        .IN_DATA   (IN_DATA),
        .IN_HIT    (IN_HIT),
        .INTERRUPT (INTERRUPT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: PEND set from the input sampled two edges earlier (level) or
    // a 0->1 between samples three and two edges earlier (edge).
    task automatic model_step();
        logic [7:0] s2, s3, setv, clr;
        bit act;
        if (RESET) begin
            m_pend = 0; m_mask = 0; m_lvl = 0;
            m_smp[0] = 0; m_smp[1] = 0; m_smp[2] = 0;
            m_intr = 0; m_quiet = 0;
            return;
        end
        s2 = m_smp[1];
        s3 = m_smp[2];
        setv = (m_lvl & s2) | (~m_lvl & s2 & ~s3);
        act = (m_pend & m_mask) != 0;
        if (m_intr) begin
            if (!act) begin
                m_intr = 0;
                m_quiet = HO;
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else if (act) begin
            m_intr = 1;
        end
        clr = (IO_STRB && PORT_ID == 8'h30) ? OUT_PORT : 8'h00;
        m_pend = setv | (m_pend & ~clr);
        if (IO_STRB && PORT_ID == 8'h31) m_mask = OUT_PORT;
        if (IO_STRB && PORT_ID == 8'h32) m_lvl = OUT_PORT;
        m_smp[2] = m_smp[1];
        m_smp[1] = m_smp[0];
        m_smp[0] = IRQ_IN;
    endtask

    // {hit, data} expected for a read of the given port
    function automatic logic [8:0] model_read(input logic [7:0] port);
        logic [7:0] a;
        int k;
        a = m_pend & m_mask;
        case (port)
            8'h30: return {1'b1, m_pend};
            8'h31: return {1'b1, m_mask};
            8'h32: return {1'b1, m_lvl};
`ifdef RAT_INTC_VECTOR_EN
            8'h33: begin
                if (a == 0) return 9'h100;
                k = 0;
                for (int b = 7; b >= 0; b--) if (a[b]) k = b;
                return {1'b1, 1'b1, 4'b0000, 3'(k)};
            end
`endif
            default: return 9'h000;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check("intr", {31'b0, INTERRUPT}, {31'b0, m_intr});
    endtask

    task automatic read_chk(input string tag, input logic [7:0] port);
        logic [8:0] e;
        IO_STRB = 0;
        PORT_ID = port;
        #1;
        e = model_read(port);
        check({tag, "_data"}, {24'b0, IN_DATA}, {24'b0, e[7:0]});
        check({tag, "_hit"}, {31'b0, IN_HIT}, {31'b0, e[8]});
    endtask

    task automatic read_const(input string tag, input logic [7:0] port,
                              input logic hit, input logic [7:0] data);
        read_chk(tag, port);
        check({tag, "_cdata"}, {24'b0, IN_DATA}, {24'b0, data});
        check({tag, "_chit"}, {31'b0, IN_HIT}, {31'b0, hit});
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        PORT_ID = port;
        OUT_PORT = data;
        IO_STRB = 1;
        tick();
        IO_STRB = 0;
    endtask

    initial begin
        int low;
        logic [7:0] ports [5];
        ports[0] = 8'h30; ports[1] = 8'h31; ports[2] = 8'h32;
        ports[3] = 8'h33; ports[4] = 8'h40;
        m_smp[0] = 0; m_smp[1] = 0; m_smp[2] = 0;

        // reset with all requests high
        RESET = 1; IRQ_IN = 8'hFF;
        tick(); tick();
        check("rst_intr", {31'b0, INTERRUPT}, 32'd0);
        read_const("rst_stat", 8'h30, 1'b1, 8'h00);
        read_const("rst_mask", 8'h31, 1'b1, 8'h00);
        read_const("rst_lvl",  8'h32, 1'b1, 8'h00);
        IRQ_IN = 8'h00;
        tick();
        RESET = 0;
        tick();

        // edge latency
        io_write(8'h31, 8'h01);
        io_write(8'h32, 8'h00);
        IRQ_IN = 8'h01;
        tick();                                   // E
        tick();                                   // E+1
        read_const("lat_e1", 8'h30, 1'b1, 8'h00);
        tick();                                   // E+2
        read_const("lat_e2", 8'h30, 1'b1, 8'h01);
        check("lat_e2_intr", {31'b0, INTERRUPT}, 32'd0);
        tick();                                   // E+3
        check("lat_e3_intr", {31'b0, INTERRUPT}, 32'd1);
        io_write(8'h30, 8'h01);
        read_const("w1c_stat", 8'h30, 1'b1, 8'h00);
        check("w1c_intr_hold", {31'b0, INTERRUPT}, 32'd1);
        tick();
        check("w1c_intr_fall", {31'b0, INTERRUPT}, 32'd0);
        IRQ_IN = 8'h00;
        repeat (8) tick();

        // hold-off
        io_write(8'h31, 8'h03);
        IRQ_IN = 8'h02;
        tick();
        IRQ_IN = 8'h00;
        for (int i = 0; i < 10 && !INTERRUPT; i++) tick();
        check("ho_rise", {31'b0, INTERRUPT}, 32'd1);
        io_write(8'h30, 8'h02);
        tick();
        check("ho_fall", {31'b0, INTERRUPT}, 32'd0);
        low = 1;
        IRQ_IN = 8'h02;
        tick();
        if (!INTERRUPT) low++;
        IRQ_IN = 8'h00;
        for (int i = 0; i < 20 && !INTERRUPT; i++) begin
            tick();
            if (!INTERRUPT) low++;
        end
        check("ho_low_cycles", low, HO + 1);
        check("ho_rerise", {31'b0, INTERRUPT}, 32'd1);
        io_write(8'h30, 8'hFF);
        repeat (8) tick();

        // collision: W1C on the edge where the set fires
        IRQ_IN = 8'h04;
        tick();
        tick();
        io_write(8'h30, 8'h04);
        read_const("coll_stat", 8'h30, 1'b1, 8'h04);
        IRQ_IN = 8'h00;
        io_write(8'h30, 8'hFF);
        repeat (8) tick();

        // level mode
        io_write(8'h32, 8'h08);
        io_write(8'h31, 8'h08);
        IRQ_IN = 8'h08;
        for (int i = 0; i < 10 && !INTERRUPT; i++) tick();
        check("lvl_rise", {31'b0, INTERRUPT}, 32'd1);
        io_write(8'h30, 8'h08);
        read_const("lvl_reset", 8'h30, 1'b1, 8'h08);
        tick();
        check("lvl_intr_held", {31'b0, INTERRUPT}, 32'd1);
        IRQ_IN = 8'h00;
        repeat (3) tick();
        io_write(8'h30, 8'h08);
        tick();
        check("lvl_intr_fall", {31'b0, INTERRUPT}, 32'd0);
        repeat (8) tick();

        // mask and vector
        io_write(8'h32, 8'h00);
        io_write(8'h30, 8'hFF);
        io_write(8'h31, 8'hF0);
        IRQ_IN = 8'h28;
        tick();
        IRQ_IN = 8'h00;
        repeat (4) tick();
        read_const("vec_stat", 8'h30, 1'b1, 8'h28);
`ifdef RAT_INTC_VECTOR_EN
        read_const("vec_85", 8'h33, 1'b1, 8'h85);
`else
        read_const("vec_unmapped", 8'h33, 1'b0, 8'h00);
`endif
        io_write(8'h31, 8'h00);
        tick();
        check("mask_off_intr", {31'b0, INTERRUPT}, 32'd0);
`ifdef RAT_INTC_VECTOR_EN
        read_const("vec_00", 8'h33, 1'b1, 8'h00);
`endif
        read_const("unmapped_40", 8'h40, 1'b0, 8'h00);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            int r;
            if ($urandom_range(0, 3) == 0) IRQ_IN = 8'($urandom);
            RESET = ($urandom_range(0, 149) == 0);
            r = $urandom_range(0, 9);
            if (r < 3) begin
                PORT_ID = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ports[$urandom_range(0, 4)];
                OUT_PORT = 8'($urandom);
                IO_STRB = 1;
            end else if (r < 7) begin
                read_chk("rnd_rd", ports[$urandom_range(0, 4)]);
            end
            tick();
            IO_STRB = 0;
            RESET = 0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
